// File: rtl/low_pass_cascade_mc.sv
// Time-multiplexed, multi-channel cascade of first-order low-pass sections.
// A single shared arithmetic engine evaluates one section per clock.
module low_pass_cascade_mc #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 2,
    parameter int STAGES = 2,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int OW    = $clog2(STAGES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic [CW-1:0]           chan_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [WIDTH-1:0]        gain_i,
    input  logic [WIDTH-1:0]        cutoff_i,
    input  logic [OW-1:0]           order_i,
    input  logic                    coef_load_i,
    input  logic                    clear_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic [CW-1:0]           chan_o,
    output logic                    valid_o,
    output logic                    sat_o,
    output logic                    err_o,
    output logic [1:0]              state_o
);

    localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int AW = 2 * WIDTH + 2;

    // Handshake: a sample transfers on a rising edge where valid_i && ready_o;
    // ready_o only depends on state and clear_i, never on valid_i.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] x_q;
    logic [CW-1:0]           ch_q;
    logic [KW-1:0]           k_q;
    logic [WIDTH-1:0]        g_q, c_q, pg_q, pc_q;
    logic [OW-1:0]           ord_q, pord_q;
    logic                    pend_q;
    logic                    sat_acc_q;

    logic signed [WIDTH-1:0] xp_q [NCH][STAGES];
    logic signed [WIDTH-1:0] yp_q [NCH][STAGES];

    logic                    chan_ok;
    logic                    last_stage;
    logic signed [WIDTH-1:0] xp_sel, yp_sel;
    logic signed [WIDTH:0]   sum;
    logic signed [AW-1:0]    p_g, p_c, acc;
    logic signed [WIDTH+1:0] hi;
    logic                    sat_now;
    logic signed [WIDTH-1:0] y_sat;
    logic                    unused_acc_lo;

    function automatic logic [OW-1:0] clamp_ord(input logic [OW-1:0] o);
        if (o == '0) begin
            return OW'(1);
        end else if (int'(o) > STAGES) begin
            return OW'(STAGES);
        end else begin
            return o;
        end
    endfunction

    assign ready_o    = (state_q == S_IDLE) && !clear_i;
    assign valid_o    = (state_q == S_OUT);
    assign state_o    = state_q;
    assign chan_ok    = int'(chan_i) < NCH;
    assign last_stage = (int'(k_q) == int'(ord_q) - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i && ready_o && chan_ok) state_d = S_RUN;
            S_RUN:   if (last_stage) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shifting right by WIDTH keeps acc[AW-1:WIDTH]; the section saturates
    // when the top three bits of that slice disagree.
    always_comb begin
        xp_sel  = xp_q[ch_q][k_q];
        yp_sel  = yp_q[ch_q][k_q];
        sum     = {x_q[WIDTH-1], x_q} + {xp_sel[WIDTH-1], xp_sel};
        p_g     = AW'(signed'({1'b0, g_q})) * AW'(sum);
        p_c     = AW'(signed'({1'b0, c_q})) * AW'(yp_sel);
        acc     = p_g + p_c;
        hi      = acc[AW-1:WIDTH];
        sat_now = !((&hi[WIDTH+1:WIDTH-1]) || (~|hi[WIDTH+1:WIDTH-1]));
        y_sat   = hi[WIDTH-1:0];
        if (sat_now) begin
            y_sat = hi[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    assign unused_acc_lo = ^acc[WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            ch_q      <= '0;
            k_q       <= '0;
            g_q       <= '0;
            c_q       <= '0;
            ord_q     <= OW'(1);
            pg_q      <= '0;
            pc_q      <= '0;
            pord_q    <= OW'(1);
            pend_q    <= 1'b0;
            sat_acc_q <= 1'b0;
            data_o    <= '0;
            chan_o    <= '0;
            sat_o     <= 1'b0;
            err_o     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                for (int j = 0; j < STAGES; j++) begin
                    xp_q[i][j] <= '0;
                    yp_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            err_o   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        for (int i = 0; i < NCH; i++) begin
                            for (int j = 0; j < STAGES; j++) begin
                                xp_q[i][j] <= '0;
                                yp_q[i][j] <= '0;
                            end
                        end
                    end
                    if (coef_load_i) begin
                        g_q   <= gain_i;
                        c_q   <= cutoff_i;
                        ord_q <= clamp_ord(order_i);
                    end
                    if (valid_i && ready_o) begin
                        if (chan_ok) begin
                            x_q       <= data_i;
                            ch_q      <= chan_i;
                            k_q       <= '0;
                            sat_acc_q <= 1'b0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    xp_q[ch_q][k_q] <= x_q;
                    yp_q[ch_q][k_q] <= y_sat;
                    x_q             <= y_sat;
                    sat_acc_q       <= sat_acc_q | sat_now;
                    if (last_stage) begin
                        data_o <= y_sat;
                        chan_o <= ch_q;
                        sat_o  <= sat_acc_q | sat_now;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                    if (coef_load_i) begin
                        pend_q <= 1'b1;
                        pg_q   <= gain_i;
                        pc_q   <= cutoff_i;
                        pord_q <= order_i;
                    end
                end
                S_OUT: begin
                    // This edge enters IDLE: a pulse now wins over older pending values.
                    pend_q <= 1'b0;
                    if (coef_load_i) begin
                        g_q   <= gain_i;
                        c_q   <= cutoff_i;
                        ord_q <= clamp_ord(order_i);
                    end else if (pend_q) begin
                        g_q   <= pg_q;
                        c_q   <= pc_q;
                        ord_q <= clamp_ord(pord_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_low_pass_cascade_mc.sv
// Directed bench for low_pass_cascade_mc: step, isolation, saturation, order,
// deferred coefficient load, clear and out-of-range channel handling.
module tb_low_pass_cascade_mc;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic signed [15:0] data_i = '0;
    logic               chan_i = 1'b0;
    logic               valid_i = 1'b0;
    logic               ready_o;
    logic [15:0]        gain_i = '0;
    logic [15:0]        cutoff_i = '0;
    logic [1:0]         order_i = 2'd1;
    logic               coef_load_i = 1'b0;
    logic               clear_i = 1'b0;
    logic signed [15:0] data_o;
    logic               chan_o;
    logic               valid_o;
    logic               sat_o;
    logic               err_o;
    logic [1:0]         state_o;

    logic [1:0]         chan3_i = '0;
    logic               valid3_i = 1'b0;
    logic               ready3_o;
    logic signed [15:0] data3_o;
    logic [1:0]         chan3_o;
    logic               valid3_o;
    logic               sat3_o;
    logic               err3_o;
    logic [1:0]         state3_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    low_pass_cascade_mc dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .chan_i(chan_i),
        .valid_i(valid_i), .ready_o(ready_o), .gain_i(gain_i), .cutoff_i(cutoff_i),
        .order_i(order_i), .coef_load_i(coef_load_i), .clear_i(clear_i),
        .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o), .sat_o(sat_o),
        .err_o(err_o), .state_o(state_o)
    );

    low_pass_cascade_mc #(.NCH(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .chan_i(chan3_i),
        .valid_i(valid3_i), .ready_o(ready3_o), .gain_i(gain_i), .cutoff_i(cutoff_i),
        .order_i(order_i), .coef_load_i(coef_load_i), .clear_i(clear_i),
        .data_o(data3_o), .chan_o(chan3_o), .valid_o(valid3_o), .sat_o(sat3_o),
        .err_o(err3_o), .state_o(state3_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int g, input int c, input int o);
        gain_i      = 16'(g);
        cutoff_i    = 16'(c);
        order_i     = 2'(o);
        coef_load_i = 1'b1;
        tick();
        coef_load_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_ready got=%0b want=0", ready_o);
        end
        tick();
        clear_i = 1'b0;
    endtask

    // Returns in cycle 1 relative to the accepting edge.
    task automatic accept(input logic ch, input int d);
        int waited = 0;
        while (!ready_o && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!ready_o) begin
            failures++;
            $display("FAIL accept_timeout ready_o stuck low");
        end
        chan_i  = ch;
        data_i  = 16'(d);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic collect(input int start, output logic signed [15:0] d, output logic c,
                           output logic s, output int lat, output bit rdy_hi);
        lat = -1;
        rdy_hi = 1'b0;
        d = 'x;
        c = 'x;
        s = 'x;
        for (int cy = start; cy < start + 20; cy++) begin
            if (ready_o) rdy_hi = 1'b1;
            if (valid_o) begin
                lat = cy;
                d = data_o;
                c = chan_o;
                s = sat_o;
                break;
            end
            tick();
        end
        if (lat >= 0) tick();
    endtask

    task automatic test_reset();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        bit seen_valid;
        rst_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (data_o !== 16'sd0 || chan_o !== 1'b0 || valid_o !== 1'b0 || sat_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got data=%0d chan=%0b valid=%0b sat=%0b err=%0b want all 0",
                     data_o, chan_o, valid_o, sat_o, err_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b want=1", ready_o);
        end
        // Reset shadows: G=0, C=0, ORD=1 -> zero output two cycles after accept.
        accept(1'b1, 1234);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd0 || lat != 2 || c !== 1'b1) begin
            failures++;
            $display("FAIL reset_coefs got data=%0d lat=%0d chan=%0b want data=0 lat=2 chan=1", d, lat, c);
        end
        // Reset in the middle of RUN drops the sample.
        load(16384, 32768, 2);
        accept(1'b0, 1000);
        rst_i = 1'b1;
        seen_valid = 1'b0;
        repeat (3) begin
            tick();
            if (valid_o) seen_valid = 1'b1;
        end
        rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || data_o !== 16'sd0) begin
            failures++;
            $display("FAIL midrun_reset got ready=%0b data=%0d want ready=1 data=0", ready_o, data_o);
        end
        repeat (5) begin
            tick();
            if (valid_o) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL midrun_valid got valid_o=1 want no strobe");
        end
        load(16384, 32768, 1);
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd250) begin
            failures++;
            $display("FAIL midrun_history got=%0d want=250", d);
        end
    endtask

    task automatic test_step();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        logic signed [15:0] exp_y [3];
        exp_y[0] = 16'sd250;
        exp_y[1] = 16'sd625;
        exp_y[2] = 16'sd812;
        do_clear();
        load(16384, 32768, 1);
        for (int i = 0; i < 3; i++) begin
            accept(1'b0, 1000);
            collect(1, d, c, s, lat, rh);
            checks++;
            if (d !== exp_y[i] || c !== 1'b0 || s !== 1'b0) begin
                failures++;
                $display("FAIL step_%0d got data=%0d chan=%0b sat=%0b want data=%0d chan=0 sat=0",
                         i, d, c, s, exp_y[i]);
            end
            checks++;
            if (lat != 2 || rh) begin
                failures++;
                $display("FAIL step_timing_%0d got lat=%0d ready_hi=%0b want lat=2 ready_hi=0", i, lat, rh);
            end
        end
        repeat (3) tick();
        checks++;
        if (data_o !== 16'sd812 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL step_hold got data=%0d valid=%0b want data=812 valid=0", data_o, valid_o);
        end
    endtask

    task automatic test_isolation();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        accept(1'b1, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd250 || c !== 1'b1) begin
            failures++;
            $display("FAIL iso_ch1 got data=%0d chan=%0b want data=250 chan=1", d, c);
        end
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd906 || c !== 1'b0) begin
            failures++;
            $display("FAIL iso_ch0 got data=%0d chan=%0b want data=906 chan=0", d, c);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        int in_v [4];
        logic ch_v [4];
        logic signed [15:0] exp_y [4];
        logic exp_s [4];
        in_v  = '{32767, 32767, -32768, -32768};
        ch_v  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_y = '{16'sd32766, 16'sd32767, -16'sd32768, -16'sd32768};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_clear();
        load(65535, 0, 1);
        for (int i = 0; i < 4; i++) begin
            accept(ch_v[i], in_v[i]);
            collect(1, d, c, s, lat, rh);
            checks++;
            if (d !== exp_y[i] || s !== exp_s[i] || c !== ch_v[i]) begin
                failures++;
                $display("FAIL sat_%0d got data=%0d sat=%0b chan=%0b want data=%0d sat=%0b chan=%0b",
                         i, d, s, c, exp_y[i], exp_s[i], ch_v[i]);
            end
        end
    endtask

    task automatic test_order2();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        do_clear();
        load(16384, 32768, 2);
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd62 || lat != 3 || rh) begin
            failures++;
            $display("FAIL order2 got data=%0d lat=%0d ready_hi=%0b want data=62 lat=3 ready_hi=0", d, lat, rh);
        end
        // Dropping to one section leaves section-1 history for later.
        load(16384, 32768, 1);
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd625 || lat != 2) begin
            failures++;
            $display("FAIL order1_after2 got data=%0d lat=%0d want data=625 lat=2", d, lat);
        end
        load(16384, 32768, 2);
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd296 || lat != 3) begin
            failures++;
            $display("FAIL order2_history got data=%0d lat=%0d want data=296 lat=3", d, lat);
        end
        do_clear();
        load(16384, 32768, 3);
        accept(1'b1, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd62 || lat != 3) begin
            failures++;
            $display("FAIL order_clamp_hi got data=%0d lat=%0d want data=62 lat=3", d, lat);
        end
        do_clear();
        load(16384, 32768, 0);
        accept(1'b1, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd250 || lat != 2) begin
            failures++;
            $display("FAIL order_clamp_lo got data=%0d lat=%0d want data=250 lat=2", d, lat);
        end
    endtask

    task automatic test_deferred_load();
        logic signed [15:0] d;
        logic c, s;
        int lat;
        bit rh;
        do_clear();
        load(16384, 32768, 1);
        accept(1'b0, 1000);
        gain_i      = 16'd0;
        cutoff_i    = 16'd0;
        order_i     = 2'd2;
        coef_load_i = 1'b1;
        tick();
        coef_load_i = 1'b0;
        collect(2, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd250 || lat != 2) begin
            failures++;
            $display("FAIL deferred_old got data=%0d lat=%0d want data=250 lat=2", d, lat);
        end
        accept(1'b0, 1000);
        collect(1, d, c, s, lat, rh);
        checks++;
        if (d !== 16'sd0 || lat != 3) begin
            failures++;
            $display("FAIL deferred_new got data=%0d lat=%0d want data=0 lat=3", d, lat);
        end
    endtask

    task automatic test_error();
        bit seen_valid;
        do_clear();
        load(16384, 32768, 1);
        chan3_i  = 2'd3;
        data_i   = 16'sd1000;
        valid3_i = 1'b1;
        tick();
        valid3_i = 1'b0;
        checks++;
        if (err3_o !== 1'b1 || ready3_o !== 1'b1 || valid3_o !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse got err=%0b ready=%0b valid=%0b want err=1 ready=1 valid=0",
                     err3_o, ready3_o, valid3_o);
        end
        seen_valid = 1'b0;
        tick();
        checks++;
        if (err3_o !== 1'b0) begin
            failures++;
            $display("FAIL err_width got err=%0b want=0", err3_o);
        end
        repeat (3) begin
            if (valid3_o) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL err_valid got valid_o=1 want no strobe");
        end
        for (int i = 0; i < 2; i++) begin
            chan3_i  = (i == 0) ? 2'd2 : 2'd0;
            data_i   = 16'sd1000;
            valid3_i = 1'b1;
            tick();
            valid3_i = 1'b0;
            tick();
            checks++;
            if (valid3_o !== 1'b1 || data3_o !== 16'sd250 || chan3_o !== chan3_i) begin
                failures++;
                $display("FAIL err_after_%0d got valid=%0b data=%0d chan=%0d want valid=1 data=250 chan=%0d",
                         i, valid3_o, data3_o, chan3_o, chan3_i);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_isolation();
        test_saturation();
        test_order2();
        test_deferred_load();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
